// File: rtl/alu_muldiv_pkg.sv
// alu_muldiv_pkg: shared opcodes, FSM state encodings and small decode helpers
// for the iterative multiply/divide unit.
//   md_op_e    : 3-bit operation codes driven on i_operation
//   md_state_e : FSM states of the sequencer
//   MD_DZ_FILL : bit replicated across LO on a divide by zero
package alu_muldiv_pkg;

  localparam int MD_PROC_BITS = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  // Divide by zero leaves LO all ones.
  localparam logic MD_DZ_FILL = 1'b1;

  function automatic logic md_is_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: request/response bundle between the EX stage and the
// multiply/divide unit.
//   master : pipeline side, drives i_start/i_operation/i_dataA/i_dataB/i_cancel
//   slave  : unit side, drives o_busy/o_done/o_hi/o_lo
interface alu_muldiv_if
  import alu_muldiv_pkg::*;
#(
  parameter int PROC_BITS = MD_PROC_BITS
);
  logic                 i_start;
  logic [2:0]           i_operation;
  logic [PROC_BITS-1:0] i_dataA;
  logic [PROC_BITS-1:0] i_dataB;
  logic                 i_cancel;
  logic                 o_busy;
  logic                 o_done;
  logic [PROC_BITS-1:0] o_hi;
  logic [PROC_BITS-1:0] o_lo;

  modport master (
    output i_start, i_operation, i_dataA, i_dataB, i_cancel,
    input  o_busy, o_done, o_hi, o_lo
  );

  modport slave (
    input  i_start, i_operation, i_dataA, i_dataB, i_cancel,
    output o_busy, o_done, o_hi, o_lo
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// muldiv_iter: one combinational iteration of the unsigned multiply/divide.
//   mode_div=0 : shift-add multiply. {hi,lo} is the 2W accumulator, lo holds
//                the remaining multiplier bits, opnd is the multiplicand.
//   mode_div=1 : restoring divide. hi is the partial remainder, lo shifts the
//                dividend out at the top and quotient bits in at the bottom,
//                opnd is the divisor.
// Ports: mode_div, hi_in, lo_in, opnd (in); hi_out, lo_out (out).
module muldiv_iter #(
  parameter int W = 32
) (
  input  logic         mode_div,
  input  logic [W-1:0] hi_in,
  input  logic [W-1:0] lo_in,
  input  logic [W-1:0] opnd,
  output logic [W-1:0] hi_out,
  output logic [W-1:0] lo_out
);
  logic [W:0] sum;
  logic [W:0] shifted;
  logic [W:0] diff;
  logic       fits;

  always_comb begin
    sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    // Remainder < divisor, so the shifted remainder needs one guard bit and
    // the borrow of the trial subtraction lands in bit W.
    shifted = {hi_in, lo_in[W-1]};
    diff    = shifted - {1'b0, opnd};
    fits    = ~diff[W];
    if (mode_div) begin
      hi_out = fits ? diff[W-1:0] : shifted[W-1:0];
      lo_out = {lo_in[W-2:0], fits};
    end else begin
      hi_out = sum[W:1];
      lo_out = {sum[0], lo_in[W-1:1]};
    end
  end
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative signed/unsigned MULT/DIV with architectural HI/LO.
// One bit per clock on operand magnitudes, followed by a single sign-fix
// cycle. MTHI/MTLO write HI/LO directly while idle.
// Ports:
//   i_clock, i_reset : clock, asynchronous active-high reset
//   bus (slave)      : start/op/operands/cancel in, busy/done/hi/lo out
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int PROC_BITS = MD_PROC_BITS,
  parameter int CNT_BITS  = $clog2(PROC_BITS) + 1
) (
  input  logic         i_clock,
  input  logic         i_reset,
  alu_muldiv_if.slave  bus
);
  localparam int W = PROC_BITS;

  md_state_e state_q, state_d;

  logic [CNT_BITS-1:0] cnt_q;
  logic [W-1:0]        wr_hi_q, wr_lo_q, opnd_q, a_raw_q;
  logic [W-1:0]        hi_q, lo_q;
  logic                is_div_q, neg_q_q, neg_r_q, dz_q, done_q;

  logic [2:0]          op;
  logic                accept, start_arith, start_mthi, start_mtlo;
  logic                a_sgn, b_sgn;
  logic [W-1:0]        a_mag, b_mag;
  logic [W-1:0]        step_hi, step_lo;
  logic [2*W-1:0]      prod, prod_fix;
  logic [W-1:0]        fix_hi, fix_lo;

  assign op          = bus.i_operation;
  // Cancel has priority over a start arriving in the same idle cycle.
  assign accept      = (state_q == MD_IDLE) && bus.i_start && !bus.i_cancel;
  assign start_arith = accept && md_is_arith(op);
  assign start_mthi  = accept && (op == MD_MTHI);
  assign start_mtlo  = accept && (op == MD_MTLO);

  // Iterate on magnitudes; most-negative maps to itself and is still the
  // correct unsigned magnitude in W bits.
  assign a_sgn = md_is_signed(op) && bus.i_dataA[W-1];
  assign b_sgn = md_is_signed(op) && bus.i_dataB[W-1];
  assign a_mag = a_sgn ? -bus.i_dataA : bus.i_dataA;
  assign b_mag = b_sgn ? -bus.i_dataB : bus.i_dataB;

  muldiv_iter #(.W(W)) u_iter (
    .mode_div (is_div_q),
    .hi_in    (wr_hi_q),
    .lo_in    (wr_lo_q),
    .opnd     (opnd_q),
    .hi_out   (step_hi),
    .lo_out   (step_lo)
  );

  // Sign correction applied in FIX.
  always_comb begin
    prod     = {wr_hi_q, wr_lo_q};
    prod_fix = neg_q_q ? -prod : prod;
    fix_hi   = prod_fix[2*W-1:W];
    fix_lo   = prod_fix[W-1:0];
    if (dz_q) begin
      fix_hi = a_raw_q;
      fix_lo = {W{MD_DZ_FILL}};
    end else if (is_div_q) begin
      fix_hi = neg_r_q ? -wr_hi_q : wr_hi_q;
      fix_lo = neg_q_q ? -wr_lo_q : wr_lo_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (start_arith) state_d = MD_CALC;
      MD_CALC: begin
        if (bus.i_cancel)                   state_d = MD_IDLE;
        else if (cnt_q == CNT_BITS'(1))     state_d = MD_FIX;
      end
      MD_FIX:  state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state_q <= MD_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cnt_q    <= '0;
      wr_hi_q  <= '0;
      wr_lo_q  <= '0;
      opnd_q   <= '0;
      a_raw_q  <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_arith) begin
        cnt_q    <= CNT_BITS'(W);
        is_div_q <= md_is_div(op);
        neg_q_q  <= a_sgn ^ b_sgn;
        neg_r_q  <= a_sgn;
        dz_q     <= md_is_div(op) && (bus.i_dataB == '0);
        a_raw_q  <= bus.i_dataA;
        wr_hi_q  <= '0;
        if (md_is_div(op)) begin
          wr_lo_q <= a_mag;
          opnd_q  <= b_mag;
        end else begin
          wr_lo_q <= b_mag;
          opnd_q  <= a_mag;
        end
      end else if (state_q == MD_CALC && !bus.i_cancel) begin
        wr_hi_q <= step_hi;
        wr_lo_q <= step_lo;
        cnt_q   <= cnt_q - CNT_BITS'(1);
      end
      if (state_q == MD_FIX && !bus.i_cancel) begin
        hi_q   <= fix_hi;
        lo_q   <= fix_lo;
        done_q <= 1'b1;
      end
      if (start_mthi) hi_q <= bus.i_dataA;
      if (start_mtlo) lo_q <= bus.i_dataA;
    end
  end

  assign bus.o_busy = (state_q != MD_IDLE);
  assign bus.o_done = done_q;
  assign bus.o_hi   = hi_q;
  assign bus.o_lo   = lo_q;
endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;
  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_muldiv_if #(.PROC_BITS(W)) bus ();

  alu_muldiv #(.PROC_BITS(W)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic. Returns {hi, lo}.
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] r, qv, mv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (op)
      3'd0: r = 64'(sa * sb);
      3'd1: r = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else begin
          qv = 64'(sa / sb);
          mv = 64'(sa % sb);
          r  = {mv[31:0], qv[31:0]};
        end
      end
      3'd3: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else        r = {a % b, a / b};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] sp [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = sp[$urandom_range(0, 4)];
      1: begin
        v = 32'($urandom_range(0, 20));
        if ($urandom_range(0, 1) == 1) v = -v;
      end
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Drive a one-cycle request; returns just after the accepting edge.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.i_start     = 1'b1;
    bus.i_operation = op;
    bus.i_dataA     = a;
    bus.i_dataB     = b;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
  endtask

  // Start an op and wait (bounded) for o_done; lat=-1 on timeout.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output int lat, output bit busy_ok);
    start_op(op, a, b);
    busy_ok = (bus.o_busy === 1'b1);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (bus.o_done === 1'b1) begin
        lat = k;
        if (bus.o_busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (bus.o_busy !== 1'b1) busy_ok = 1'b0;
    end
    hi = bus.o_hi;
    lo = bus.o_lo;
  endtask

  task automatic test_reset();
    n_checks += 4;
    if (bus.o_hi !== '0)   begin n_fail++; $display("FAIL reset_hi: got %h want 0", bus.o_hi); end
    if (bus.o_lo !== '0)   begin n_fail++; $display("FAIL reset_lo: got %h want 0", bus.o_lo); end
    if (bus.o_busy !== 0)  begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
    if (bus.o_done !== 0)  begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.o_done); end
  endtask

  task automatic test_mt();
    start_op(3'b100, 32'h1234, 32'h0);
    n_checks += 3;
    if (bus.o_hi !== 32'h1234) begin n_fail++; $display("FAIL mthi: got %h want 00001234", bus.o_hi); end
    if (bus.o_done !== 1'b0)   begin n_fail++; $display("FAIL mthi_done: got %b want 0", bus.o_done); end
    if (bus.o_busy !== 1'b0)   begin n_fail++; $display("FAIL mthi_busy: got %b want 0", bus.o_busy); end
    start_op(3'b101, 32'hABCD_0001, 32'h0);
    n_checks += 2;
    if (bus.o_lo !== 32'hABCD_0001) begin n_fail++; $display("FAIL mtlo: got %h want abcd0001", bus.o_lo); end
    if (bus.o_hi !== 32'h1234)      begin n_fail++; $display("FAIL mtlo_hi: got %h want 00001234", bus.o_hi); end
    // undefined opcode: nothing changes
    start_op(3'b110, 32'hDEAD_BEEF, 32'h3);
    n_checks += 3;
    if (bus.o_busy !== 1'b0)        begin n_fail++; $display("FAIL noop_busy: got %b want 0", bus.o_busy); end
    if (bus.o_hi !== 32'h1234)      begin n_fail++; $display("FAIL noop_hi: got %h want 00001234", bus.o_hi); end
    if (bus.o_lo !== 32'hABCD_0001) begin n_fail++; $display("FAIL noop_lo: got %h want abcd0001", bus.o_lo); end
    // cancel beats start in idle
    bus.i_cancel = 1'b1;
    start_op(3'b100, 32'h5555, 32'h0);
    start_op(3'b000, 32'h7, 32'h3);
    n_checks += 2;
    if (bus.o_hi !== 32'h1234) begin n_fail++; $display("FAIL cancel_mthi: got %h want 00001234", bus.o_hi); end
    if (bus.o_busy !== 1'b0)   begin n_fail++; $display("FAIL cancel_start_busy: got %b want 0", bus.o_busy); end
    @(negedge clk);
    bus.i_cancel = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]  op_t [7] = '{3'd1, 3'd0, 3'd0, 3'd2, 3'd3, 3'd2, 3'd3};
    logic [31:0] a_t  [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd5};
    logic [31:0] b_t  [7] = '{32'hFFFF_FFFF, 32'd3, 32'h8000_0000, 32'd2, 32'd7, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] eh_t [7] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd5};
    logic [31:0] el_t [7] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'h0, 32'hFFFF_FFFD, 32'd14, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] hi, lo;
    int lat;
    bit bok;
    for (int i = 0; i < 7; i++) begin
      run_op(op_t[i], a_t[i], b_t[i], hi, lo, lat, bok);
      n_checks += 4;
      if (hi !== eh_t[i]) begin n_fail++; $display("FAIL dir%0d_hi: got %h want %h", i, hi, eh_t[i]); end
      if (lo !== el_t[i]) begin n_fail++; $display("FAIL dir%0d_lo: got %h want %h", i, lo, el_t[i]); end
      if (lat != LAT)     begin n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, LAT); end
      if (bok !== 1'b1)   begin n_fail++; $display("FAIL dir%0d_busy: busy window wrong, want high edges 0..%0d", i, LAT-1); end
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_width: got %b want 0", i, bus.o_done); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, pulses;
    // second start at cycle 10 must be ignored
    start_op(3'b000, 32'd6, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_operation = 3'b011; bus.i_dataA = 32'd99; bus.i_dataB = 32'd4;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    lat = -1;
    for (int k = 11; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (bus.o_done === 1'b1) begin lat = k; break; end
    end
    n_checks += 3;
    if (lat != LAT)       begin n_fail++; $display("FAIL b2b_latency: got %0d want %0d", lat, LAT); end
    if (bus.o_hi !== 0)   begin n_fail++; $display("FAIL b2b_hi: got %h want 0", bus.o_hi); end
    if (bus.o_lo !== 42)  begin n_fail++; $display("FAIL b2b_lo: got %h want 0000002a", bus.o_lo); end
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.o_done === 1'b1 || bus.o_busy === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL b2b_no_second_op: got %0d active cycles want 0", pulses); end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic [63:0] exp;
    int lat;
    bit bok;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      exp = ref_md(op, a, b);
      run_op(op, a, b, hi, lo, lat, bok);
      n_checks += 3;
      if (hi !== exp[63:32]) begin n_fail++; $display("FAIL rnd%0d_hi op%0d %h,%h: got %h want %h", i, op, a, b, hi, exp[63:32]); end
      if (lo !== exp[31:0])  begin n_fail++; $display("FAIL rnd%0d_lo op%0d %h,%h: got %h want %h", i, op, a, b, lo, exp[31:0]); end
      if (lat != LAT)        begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, LAT); end
    end
  endtask

  // Cancel sampled at edge at_edge of a DIV (1..LAT).
  task automatic test_cancel(input int at_edge);
    logic [31:0] h0, l0;
    int pulses;
    h0 = $urandom;
    l0 = $urandom;
    start_op(3'b100, h0, 32'h0);
    start_op(3'b101, l0, 32'h0);
    start_op(3'b010, 32'hFFFF_F000, 32'd3);
    repeat (at_edge - 1) @(posedge clk);
    @(negedge clk);
    bus.i_cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.i_cancel = 1'b0;
    n_checks += 3;
    if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL cancel%0d_busy: got %b want 0", at_edge, bus.o_busy); end
    if (bus.o_hi !== h0)     begin n_fail++; $display("FAIL cancel%0d_hi: got %h want %h", at_edge, bus.o_hi, h0); end
    if (bus.o_lo !== l0)     begin n_fail++; $display("FAIL cancel%0d_lo: got %h want %h", at_edge, bus.o_lo, l0); end
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.o_done === 1'b1) pulses++;
    end
    n_checks += 2;
    if (pulses != 0)     begin n_fail++; $display("FAIL cancel%0d_done: got %0d pulses want 0", at_edge, pulses); end
    if (bus.o_lo !== l0) begin n_fail++; $display("FAIL cancel%0d_lo_later: got %h want %h", at_edge, bus.o_lo, l0); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    start_op(3'b100, 32'hAAAA_5555, 32'h0);
    start_op(3'b001, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks += 4;
    if (bus.o_hi !== '0)     begin n_fail++; $display("FAIL midrst_hi: got %h want 0", bus.o_hi); end
    if (bus.o_lo !== '0)     begin n_fail++; $display("FAIL midrst_lo: got %h want 0", bus.o_lo); end
    if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", bus.o_busy); end
    if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", bus.o_done); end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.o_done === 1'b1 || bus.o_busy === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL midrst_stays_idle: got %0d active cycles want 0", pulses); end
  endtask

  initial begin
    bus.i_start     = 1'b0;
    bus.i_operation = 3'b000;
    bus.i_dataA     = '0;
    bus.i_dataB     = '0;
    bus.i_cancel    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_mt();
    test_directed();
    test_back_to_back();
    test_random();
    test_cancel(15);
    test_cancel(1);
    test_cancel(LAT);
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
